instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, program memory address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first program memory address written.
REQ-003 SHALL have port clk  input  1  clock; the block uses one clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a new program load.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, the instruction-field handshake.
REQ-007 SHALL have ports in_opcode input 4, in_rd input 4, in_rs input 4 and in_rt input 4, the instruction fields.
REQ-008 SHALL have ports in_nzp input 3 and in_imm input 8, the branch condition and immediate fields.
REQ-009 SHALL have port in_last  input  1  marks the final instruction of the program.
REQ-010 SHALL have ports mem_write_valid output 1, mem_write_ready input 1, mem_write_address output ADDR_BITS and mem_write_data output 16, the program memory write port.
REQ-011 SHALL have ports done output 1, error output 1 and instr_count output ADDR_BITS+1, the status outputs.

Function
REQ-012 SHALL implement FSM states IDLE, ACCEPT, WRITE and DONE.
REQ-013 SHALL assert in_ready only in ACCEPT; a transfer occurs on a cycle with in_valid and in_ready both high.
REQ-014 SHALL, on start in IDLE or DONE, enter ACCEPT next cycle and set address=BASE_ADDR, instr_count=0, done=0, error=0; start is ignored in ACCEPT and WRITE.
REQ-015 SHALL register the encoded word on a transfer at edge N and assert mem_write_valid from cycle N+1 (latency 1).
REQ-016 SHALL hold mem_write_valid, mem_write_address and mem_write_data stable in WRITE until mem_write_ready is high.
REQ-017 SHALL encode NOP as 0x0000, BRnzp as {0001,nzp,0,imm}, CMP as {0010,0000,rs,rt}, and ADD/SUB/MUL/DIV (0x3-0x6) as {op,rd,rs,rt}.
REQ-018 SHALL encode LDR as {0111,rd,rs,0000}, STR as {1000,0000,rs,rt}, CONST as {1001,rd,imm} and RET as 0xF000.
REQ-019 SHALL force to zero all fields unused by an opcode, regardless of input values.
REQ-020 SHALL, on the write handshake, increment address (wrapping modulo 2^ADDR_BITS) and increment instr_count.
REQ-021 SHALL, after the write handshake, go to DONE with done=1 if in_last was set, else return to ACCEPT.
REQ-022 SHALL, if the word written at address 2^ADDR_BITS-1 is not last, go to DONE with done=1 and error=1 (overflow).
REQ-023 SHALL keep done and error sticky in DONE until the next start or reset.
REQ-024 SHALL keep in_ready low during WRITE, so no new transfer is accepted while a write is pending.

Reset
REQ-025 SHALL, on reset, drive state=IDLE, in_ready=0, mem_write_valid=0, mem_write_address=0, mem_write_data=0, done=0, error=0 and instr_count=0.
REQ-026 SHALL, on reset mid-WRITE, abandon the pending write, with mem_write_valid low from the cycle after the reset edge.
REQ-027 SHALL give reset priority over start and over all handshakes.

Configuration
REQ-028 SHALL, with ENCODER_ILLEGAL_CHECK_EN defined, treat opcodes 0xA-0xE as illegal: no write, error=1, transition to DONE with done=1.
REQ-029 SHALL, without ENCODER_ILLEGAL_CHECK_EN, encode opcodes 0xA-0xE as {op,rd,rs,rt} and write them normally.

Verification
REQ-030 SHALL cover: start, then ADD rd=1 rs=2 rt=3 with in_last=1 and mem_write_ready=1 -> write 0x3123 at address 0x00, done=1, instr_count=1.
REQ-031 SHALL cover: CONST rd=5 imm=0xAB with rs/rt inputs nonzero, then BRnzp nzp=3'b101 imm=0x04 -> writes 0x95AB at 0x00 then 0x1A04 at 0x01.
REQ-032 SHALL cover: mem_write_ready held low 4 cycles during a write of STR rs=7 rt=2 -> mem_write_data stays 0x8072, in_ready stays 0, then exactly one write.
REQ-033 SHALL cover: ADDR_BITS=2 with 5 non-last instructions -> 4 writes, then done=1, error=1, in_ready=0, instr_count=4.
REQ-034 SHALL cover: opcode 0xC with ENCODER_ILLEGAL_CHECK_EN defined -> no write, error=1; without the macro -> write {0xC,rd,rs,rt}.
REQ-035 SHALL cover: reset asserted while mem_write_valid=1 -> all outputs zero next cycle; a following start restarts the load at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction-field encoder: packs instruction fields into 16-bit words and streams them into program memory.
// Optional build macro ENCODER_ILLEGAL_CHECK_EN rejects opcodes 0xA-0xE instead of writing them.
module instr_encoder #(
  parameter int ADDR_BITS = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_opcode,
  input  logic [3:0]           in_rd,
  input  logic [3:0]           in_rs,
  input  logic [3:0]           in_rt,
  input  logic [2:0]           in_nzp,
  input  logic [7:0]           in_imm,
  input  logic                 in_last,
  output logic                 mem_write_valid,
  input  logic                 mem_write_ready,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [15:0]          mem_write_data,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_BITS:0]   instr_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_START = BASE_ADDR[ADDR_BITS-1:0];
  localparam logic [ADDR_BITS-1:0] ADDR_LAST  = '1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE   = 1;
  localparam logic [ADDR_BITS:0]   CNT_ONE    = 1;

  state_t               state_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS:0]   count_q;
  logic [15:0]          data_q;
  logic                 valid_q;
  logic                 last_q;
  logic                 done_q;
  logic                 error_q;

  logic [15:0]          enc_d;
  logic                 illegal_d;

  // Fields an opcode does not use are forced to zero here.
  always_comb begin
    enc_d = 16'h0000;
    case (in_opcode)
      4'h0:                      enc_d = 16'h0000;
      4'h1:                      enc_d = {4'h1, in_nzp, 1'b0, in_imm};
      4'h2:                      enc_d = {4'h2, 4'h0, in_rs, in_rt};
      4'h3, 4'h4, 4'h5, 4'h6:    enc_d = {in_opcode, in_rd, in_rs, in_rt};
      4'h7:                      enc_d = {4'h7, in_rd, in_rs, 4'h0};
      4'h8:                      enc_d = {4'h8, 4'h0, in_rs, in_rt};
      4'h9:                      enc_d = {4'h9, in_rd, in_imm};
      4'hF:                      enc_d = 16'hF000;
      default:                   enc_d = {in_opcode, in_rd, in_rs, in_rt};
    endcase
  end

`ifdef ENCODER_ILLEGAL_CHECK_EN
  assign illegal_d = (in_opcode >= 4'hA) && (in_opcode <= 4'hE);
`else
  assign illegal_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= ACCEPT;
            addr_q  <= ADDR_START;
            count_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            if (illegal_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else begin
              state_q <= WRITE;
              data_q  <= enc_d;
              last_q  <= in_last;
              valid_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_write_ready) begin
            valid_q <= 1'b0;
            addr_q  <= addr_q + ADDR_ONE;
            count_q <= count_q + CNT_ONE;
            if (last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (addr_q == ADDR_LAST) begin
              // Top of memory reached without a last marker: overflow.
              state_q <= DONE;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else begin
              state_q <= ACCEPT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready          = (state_q == ACCEPT);
  assign mem_write_valid   = valid_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = data_q;
  assign done              = done_q;
  assign error             = error_q;
  assign instr_count       = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: opcode vector table plus stall, overflow and reset sequences.
// Honours ENCODER_ILLEGAL_CHECK_EN when deciding what opcode 0xC should do.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last, mem_write_ready;
  logic [3:0]  in_opcode, in_rd, in_rs, in_rt;
  logic [2:0]  in_nzp;
  logic [7:0]  in_imm;
  logic        in_ready, mem_write_valid, done, error;
  logic [7:0]  mem_write_address;
  logic [15:0] mem_write_data;
  logic [8:0]  instr_count;

  logic        start_s, in_valid_s, mem_write_ready_s;
  logic        in_ready_s, mem_write_valid_s, done_s, error_s;
  logic [1:0]  mem_write_address_s;
  logic [15:0] mem_write_data_s;
  logic [2:0]  instr_count_s;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int wr_cnt_s = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_BITS(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_nzp(in_nzp), .in_imm(in_imm), .in_last(in_last),
    .mem_write_valid(mem_write_valid), .mem_write_ready(mem_write_ready),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .done(done), .error(error), .instr_count(instr_count)
  );

  instr_encoder #(.ADDR_BITS(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_nzp(in_nzp), .in_imm(in_imm), .in_last(in_last),
    .mem_write_valid(mem_write_valid_s), .mem_write_ready(mem_write_ready_s),
    .mem_write_address(mem_write_address_s), .mem_write_data(mem_write_data_s),
    .done(done_s), .error(error_s), .instr_count(instr_count_s)
  );

  always @(posedge clk) begin
    if (!reset && mem_write_valid && mem_write_ready) wr_cnt++;
    if (!reset && mem_write_valid_s && mem_write_ready_s) wr_cnt_s++;
  end

  typedef struct {
    logic [3:0]  op, rd, rs, rt;
    logic [2:0]  nzp;
    logic [7:0]  imm;
    logic [15:0] exp;
    bit          illegal;
  } vec_t;

  vec_t vecs[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_s = 1'b1; else start = 1'b1;
    tick;
    start = 1'b0;
    start_s = 1'b0;
  endtask

  // Presents one instruction and waits (bounded) for the transfer edge.
  task automatic send(input logic [3:0] op, rd, rs, rt, input logic [2:0] nzp,
                      input logic [7:0] imm, input logic last, input bit sel, input string nm);
    bit got;
    got = 1'b0;
    in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_nzp = nzp; in_imm = imm; in_last = last;
    if (sel) in_valid_s = 1'b1; else in_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (sel ? in_ready_s : in_ready) got = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    in_valid_s = 1'b0;
    check({nm, "_accept"}, {31'd0, got}, 32'd1);
  endtask

  task automatic write_main;
    mem_write_ready = 1'b1;
    tick;
    mem_write_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_write_ready = 1'b0;
    start_s = 1'b0; in_valid_s = 1'b0; mem_write_ready_s = 1'b0;
    in_opcode = 4'h0; in_rd = 4'h0; in_rs = 4'h0; in_rt = 4'h0; in_nzp = 3'h0; in_imm = 8'h00;

    vecs[0]  = '{4'h0, 4'h5, 4'h6, 4'h7, 3'h7, 8'hFF, 16'h0000, 1'b0};
    vecs[1]  = '{4'h1, 4'hF, 4'hF, 4'hF, 3'h3, 8'h5A, 16'h165A, 1'b0};
    vecs[2]  = '{4'h2, 4'h9, 4'h4, 4'hB, 3'h7, 8'hFF, 16'h204B, 1'b0};
    vecs[3]  = '{4'h3, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00, 16'h3123, 1'b0};
    vecs[4]  = '{4'h4, 4'hA, 4'hB, 4'hC, 3'h7, 8'h11, 16'h4ABC, 1'b0};
    vecs[5]  = '{4'h5, 4'h1, 4'h0, 4'hF, 3'h1, 8'h22, 16'h510F, 1'b0};
    vecs[6]  = '{4'h6, 4'h2, 4'h3, 4'h4, 3'h2, 8'h33, 16'h6234, 1'b0};
    vecs[7]  = '{4'h7, 4'h8, 4'h9, 4'hF, 3'h7, 8'hFF, 16'h7890, 1'b0};
    vecs[8]  = '{4'h8, 4'hF, 4'h7, 4'h2, 3'h7, 8'hFF, 16'h8072, 1'b0};
    vecs[9]  = '{4'h9, 4'h5, 4'h1, 4'h2, 3'h7, 8'hAB, 16'h95AB, 1'b0};
`ifdef ENCODER_ILLEGAL_CHECK_EN
    vecs[10] = '{4'hC, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00, 16'h0000, 1'b1};
`else
    vecs[10] = '{4'hC, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00, 16'hC123, 1'b0};
`endif
    vecs[11] = '{4'hF, 4'h1, 4'h2, 4'h3, 3'h5, 8'h44, 16'hF000, 1'b0};

    tick; tick;
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", mem_write_valid, 0);
    check("rst_addr", mem_write_address, 0);
    check("rst_data", mem_write_data, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_count", instr_count, 0);
    reset = 1'b0;
    tick;
    check("idle_in_ready", in_ready, 0);

    // One single-instruction program per opcode.
    foreach (vecs[i]) begin
      pulse_start(1'b0);
      check($sformatf("v%0d_start_done", i), done, 0);
      w0 = wr_cnt;
      send(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].nzp, vecs[i].imm,
           1'b1, 1'b0, $sformatf("v%0d", i));
      if (vecs[i].illegal) begin
        check($sformatf("v%0d_ill_valid", i), mem_write_valid, 0);
        check($sformatf("v%0d_ill_done", i), done, 1);
        check($sformatf("v%0d_ill_error", i), error, 1);
        tick;
        check($sformatf("v%0d_ill_nowrite", i), wr_cnt - w0, 0);
      end else begin
        check($sformatf("v%0d_valid", i), mem_write_valid, 1);
        check($sformatf("v%0d_addr", i), mem_write_address, 0);
        check($sformatf("v%0d_data", i), mem_write_data, vecs[i].exp);
        write_main;
        check($sformatf("v%0d_done", i), done, 1);
        check($sformatf("v%0d_error", i), error, 0);
        check($sformatf("v%0d_count", i), instr_count, 1);
        check($sformatf("v%0d_writes", i), wr_cnt - w0, 1);
        check($sformatf("v%0d_valid_off", i), mem_write_valid, 0);
      end
    end

    // Two-instruction program: CONST then BRnzp.
    pulse_start(1'b0);
    send(4'h9, 4'h5, 4'h3, 4'h6, 3'h0, 8'hAB, 1'b0, 1'b0, "two_a");
    check("two_a_addr", mem_write_address, 8'h00);
    check("two_a_data", mem_write_data, 16'h95AB);
    write_main;
    check("two_mid_ready", in_ready, 1);
    check("two_mid_done", done, 0);
    send(4'h1, 4'h0, 4'h0, 4'h0, 3'b101, 8'h04, 1'b1, 1'b0, "two_b");
    check("two_b_addr", mem_write_address, 8'h01);
    check("two_b_data", mem_write_data, 16'h1A04);
    write_main;
    check("two_done", done, 1);
    check("two_count", instr_count, 2);

    // Back-pressure: STR held for 4 cycles, start during the stall is ignored.
    pulse_start(1'b0);
    w0 = wr_cnt;
    send(4'h8, 4'h0, 4'h7, 4'h2, 3'h0, 8'h00, 1'b1, 1'b0, "stall");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall%0d_valid", i), mem_write_valid, 1);
      check($sformatf("stall%0d_data", i), mem_write_data, 16'h8072);
      check($sformatf("stall%0d_addr", i), mem_write_address, 0);
      check($sformatf("stall%0d_in_ready", i), in_ready, 0);
      if (i == 1) start = 1'b1;
      tick;
      start = 1'b0;
    end
    write_main;
    check("stall_writes", wr_cnt - w0, 1);
    check("stall_done", done, 1);
    check("stall_count", instr_count, 1);
    tick; tick;
    check("stall_no_extra", wr_cnt - w0, 1);

    // Overflow on a 4-word memory.
    pulse_start(1'b1);
    for (int k = 0; k < 4; k++) begin
      send(4'h3, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00, 1'b0, 1'b1, $sformatf("ovf%0d", k));
      check($sformatf("ovf%0d_addr", k), mem_write_address_s, k);
      mem_write_ready_s = 1'b1;
      tick;
      mem_write_ready_s = 1'b0;
    end
    check("ovf_done", done_s, 1);
    check("ovf_error", error_s, 1);
    check("ovf_count", instr_count_s, 4);
    in_valid_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ovf_in_ready%0d", i), in_ready_s, 0);
      tick;
    end
    in_valid_s = 1'b0;
    check("ovf_writes", wr_cnt_s, 4);
    check("ovf_sticky_error", error_s, 1);

    // Reset while a write is pending, then restart.
    pulse_start(1'b0);
    send(4'h3, 4'h1, 4'h2, 4'h3, 3'h0, 8'h00, 1'b1, 1'b0, "rstw");
    check("rstw_valid_before", mem_write_valid, 1);
    reset = 1'b1;
    mem_write_ready = 1'b0;
    start = 1'b1;
    tick;
    reset = 1'b0;
    start = 1'b0;
    check("rstw_valid", mem_write_valid, 0);
    check("rstw_in_ready", in_ready, 0);
    check("rstw_addr", mem_write_address, 0);
    check("rstw_data", mem_write_data, 0);
    check("rstw_done", done, 0);
    check("rstw_error", error, 0);
    check("rstw_count", instr_count, 0);
    pulse_start(1'b0);
    w0 = wr_cnt;
    send(4'h2, 4'h0, 4'h4, 4'hB, 3'h0, 8'h00, 1'b1, 1'b0, "rstr");
    check("rstr_addr", mem_write_address, 0);
    check("rstr_data", mem_write_data, 16'h204B);
    check("rstr_count_pre", instr_count, 0);
    write_main;
    check("rstr_done", done, 1);
    check("rstr_count", instr_count, 1);
    check("rstr_writes", wr_cnt - w0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
